// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b computed LSB-first, one bit per clock
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, aborts any operation
//   start  : request, sampled only in IDLE
//   a, b   : minuend / subtrahend, captured on an accepted start
//   busy   : high while bits are being processed (RUN)
//   done   : one-cycle pulse, diff/borrow valid
//   diff   : (a - b) mod 2^WIDTH, held until the next result
//   borrow : 1 when a < b, held like diff
// Build option: define SUB_SATURATE_EN to clamp diff to 0 whenever borrow is 1.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa, sb, sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             x, y, d, br_n, last;
    logic [WIDTH-1:0] res, fin;

    always_comb begin
        x    = sa[0];
        y    = sb[0];
        d    = x ^ y ^ br;
        br_n = (~x & y) | (~(x ^ y) & br);
        last = cnt == CW'(WIDTH - 1);
        res  = {d, sr[WIDTH-1:1]};
`ifdef SUB_SATURATE_EN
        fin  = br_n ? '0 : res;
`else
        fin  = res;
`endif
    end

    assign busy = state == RUN;
    assign done = state == DONE;

    // sr is the working result register; diff only changes on the final bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sa    <= a;
                    sb    <= b;
                    br    <= 1'b0;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= res;
                    br  <= br_n;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state  <= DONE;
                        diff   <= fin;
                        borrow <= br_n;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
